// File: rtl/byte_lane_write_arbiter_pkg.sv
// Shared types and helpers for the byte-lane merging write arbiter.
package byte_lane_arb_pkg;

  localparam int REG_W   = 16;
  localparam int LANES   = 2;
  localparam int MAX_REQ = 8;

  typedef logic [LANES-1:0] lane_mask_t;

  // Index of the first set bit at or after ptr, wrapping modulo n.
  function automatic logic [2:0] rr_first(input logic [MAX_REQ-1:0] mask,
                                          input logic [2:0] ptr,
                                          input int n);
    logic [2:0] idx;
    logic       found;
    rr_first = ptr;
    found    = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = 3'((32'(ptr) + k) % n);
        if (!found && mask[idx]) begin
          rr_first = idx;
          found    = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/byte_lane_write_arbiter_if.sv
// Requester write bus and datapath read port of the byte-lane write arbiter.
interface byte_lane_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*2-1:0]  req_byteena;
  logic [NREQ*16-1:0] req_data;
  logic [AW-1:0]      rd_addr;
  logic [15:0]        rd_data;

  modport master (
    output req_valid, req_addr, req_byteena, req_data, rd_addr,
    input  req_ready, rd_data
  );

  modport slave (
    input  req_valid, req_addr, req_byteena, req_data, rd_addr,
    output req_ready, rd_data
  );
endinterface

// File: rtl/byte_lane_write_arbiter_reg16.sv
// One 16-bit register with per-byte write enables and synchronous clear.
module byte_en_reg16
  import byte_lane_arb_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  lane_mask_t       we,
  input  logic [REG_W-1:0] wdata,
  output logic [REG_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (we[l]) q[8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

endmodule

// File: rtl/byte_lane_write_arbiter.sv
// Round-robin write arbiter over a byte-enabled register bank; lower-priority
// requesters hitting the winner's register on free byte lanes ride along.
module byte_lane_write_arbiter
  import byte_lane_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NREGS = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  byte_lane_write_arbiter_if.slave  bus,
  output logic [7:0]                merge_cnt
);

  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]      addr_a [MAX_REQ];
  lane_mask_t         be_a   [MAX_REQ];
  logic [REG_W-1:0]   data_a [MAX_REQ];
  logic [MAX_REQ-1:0] elig;
  logic [MAX_REQ-1:0] grant;
  logic [2:0]         rr_ptr;
  logic [2:0]         winner;
  logic [2:0]         j;
  lane_mask_t         lanes;
  lane_mask_t         we_r   [NREGS];
  logic [REG_W-1:0]   wd_r   [NREGS];
  logic [REG_W-1:0]   q_r    [NREGS];

  // Pad the requester vectors to MAX_REQ so all indexing uses a fixed width.
  for (genvar i = 0; i < MAX_REQ; i++) begin : g_unpack
    if (i < NREQ) begin : g_real
      assign addr_a[i] = bus.req_addr[i*AW +: AW];
      assign be_a[i]   = bus.req_byteena[i*LANES +: LANES];
      assign data_a[i] = bus.req_data[i*REG_W +: REG_W];
      assign elig[i]   = bus.req_valid[i] & (|bus.req_byteena[i*LANES +: LANES]);
    end else begin : g_pad
      assign addr_a[i] = '0;
      assign be_a[i]   = '0;
      assign data_a[i] = '0;
      assign elig[i]   = 1'b0;
    end
  end

  always_comb begin
    grant  = '0;
    lanes  = '0;
    j      = '0;
    winner = rr_first(elig, rr_ptr, NREQ);
    if (resetn && (|elig)) begin
      grant[winner] = 1'b1;
      lanes         = be_a[winner];
      for (int k = 1; k < MAX_REQ; k++) begin
        if (k < NREQ) begin
          j = 3'((32'(winner) + k) % NREQ);
          if (elig[j] && (addr_a[j] == addr_a[winner]) && ((be_a[j] & lanes) == '0)) begin
            grant[j] = 1'b1;
            lanes    = lanes | be_a[j];
          end
        end
      end
    end
  end

  assign bus.req_ready = grant[NREQ-1:0];

  // Granted lanes for one address are disjoint, so OR-free steering is safe.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      we_r[r] = '0;
      wd_r[r] = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && (addr_a[i] == AW'(r))) begin
          for (int l = 0; l < LANES; l++) begin
            if (be_a[i][l]) begin
              we_r[r][l]         = 1'b1;
              wd_r[r][8*l +: 8]  = data_a[i][8*l +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_bank
    byte_en_reg16 u_reg (
      .clk    (clk),
      .resetn (resetn),
      .we     (we_r[r]),
      .wdata  (wd_r[r]),
      .q      (q_r[r])
    );
  end

  assign bus.rd_data = q_r[bus.rd_addr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr    <= '0;
      merge_cnt <= '0;
    end else begin
      if (|grant) rr_ptr <= 3'((32'(winner) + 1) % NREQ);
      if (($countones(grant) >= 2) && (merge_cnt != 8'hFF)) merge_cnt <= merge_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_byte_lane_write_arbiter.sv
// Vector-table bench for the byte-lane write arbiter with a small expectation queue.
module tb_byte_lane_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 2;

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  addr;
    logic [7:0]  be;
    logic [63:0] data;
    logic [3:0]  exp_ready;
    logic [1:0]  rd_addr;
    logic [15:0] exp_rd;
    logic [7:0]  exp_merge;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  rd_addr;
    logic [15:0] rd;
    logic [7:0]  merge;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] merge_cnt;
  int         total = 0;
  int         bad   = 0;
  vec_t       vec [18];
  exp_t       sb [$];
  exp_t       e;

  byte_lane_write_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

  byte_lane_write_arbiter #(.NREQ(NREQ), .NREGS(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .merge_cnt (merge_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b,
                       input logic [63:0] d);
    bus.req_valid   = v;
    bus.req_addr    = a;
    bus.req_byteena = b;
    bus.req_data    = d;
  endtask

  initial begin
    vec[0]  = '{4'b0001, {2'd0,2'd0,2'd0,2'd1}, {2'b00,2'b00,2'b00,2'b01},
                {16'h0,16'h0,16'h0,16'hABCD}, 4'b0001, 2'd1, 16'h00CD, 8'd0};
    vec[1]  = '{4'b0001, {2'd0,2'd0,2'd0,2'd1}, {2'b00,2'b00,2'b00,2'b10},
                {16'h0,16'h0,16'h0,16'h1234}, 4'b0001, 2'd1, 16'h12CD, 8'd0};
    vec[2]  = '{4'b1000, {2'd3,2'd0,2'd0,2'd0}, {2'b11,2'b00,2'b00,2'b00},
                {16'h3333,16'h0,16'h0,16'h0}, 4'b1000, 2'd3, 16'h3333, 8'd0};
    for (int k = 0; k < 5; k++) begin
      vec[3+k] = '{4'b1111, 8'h00, 8'hFF, {16'hC003,16'hC002,16'hC001,16'hC000},
                   4'(1 << (k % 4)), 2'd0, 16'hC000 | 16'(k % 4), 8'd0};
    end
    vec[8]  = '{4'b1000, {2'd3,2'd0,2'd0,2'd0}, {2'b01,2'b00,2'b00,2'b00},
                {16'h0077,16'h0,16'h0,16'h0}, 4'b1000, 2'd3, 16'h3377, 8'd0};
    vec[9]  = '{4'b0101, {2'd0,2'd2,2'd0,2'd2}, {2'b00,2'b10,2'b00,2'b01},
                {16'h0,16'hBB00,16'h0,16'h00AA}, 4'b0101, 2'd2, 16'hBBAA, 8'd1};
    vec[10] = '{4'b1110, {2'd0,2'd3,2'd3,2'd0}, {2'b10,2'b01,2'b11,2'b00},
                {16'h7700,16'h0099,16'h5566,16'h0}, 4'b0010, 2'd3, 16'h5566, 8'd1};
    vec[11] = '{4'b1100, {2'd0,2'd3,2'd3,2'd0}, {2'b10,2'b01,2'b00,2'b00},
                {16'h7700,16'h0099,16'h0,16'h0}, 4'b0100, 2'd3, 16'h5599, 8'd1};
    vec[12] = '{4'b1000, {2'd0,2'd0,2'd0,2'd0}, {2'b10,2'b00,2'b00,2'b00},
                {16'h7700,16'h0,16'h0,16'h0}, 4'b1000, 2'd0, 16'h7700, 8'd1};
    vec[13] = '{4'b1111, {2'd1,2'd1,2'd1,2'd1}, {2'b01,2'b01,2'b10,2'b10},
                {16'h0011,16'h00FF,16'hDD00,16'hEE00}, 4'b0101, 2'd1, 16'hEEFF, 8'd2};
    vec[14] = '{4'b0001, {2'd0,2'd0,2'd0,2'd1}, {2'b00,2'b00,2'b00,2'b00},
                {16'h0,16'h0,16'h0,16'hFFFF}, 4'b0000, 2'd1, 16'hEEFF, 8'd2};
    vec[15] = '{4'b1001, {2'd2,2'd0,2'd0,2'd2}, {2'b01,2'b00,2'b00,2'b00},
                {16'h0042,16'h0,16'h0,16'hFFFF}, 4'b1000, 2'd2, 16'hBB42, 8'd2};
    vec[16] = '{4'b0011, {2'd0,2'd0,2'd2,2'd2}, {2'b00,2'b00,2'b10,2'b00},
                {16'h0,16'h0,16'h1100,16'hFFFF}, 4'b0010, 2'd2, 16'h1142, 8'd2};
    vec[17] = '{4'b1001, {2'd0,2'd0,2'd0,2'd0}, {2'b01,2'b00,2'b00,2'b10},
                {16'h0033,16'h0,16'h0,16'h4400}, 4'b1001, 2'd0, 16'h4433, 8'd3};

    // Reset with live requests: nothing granted, nothing written.
    resetn      = 1'b0;
    bus.rd_addr = '0;
    drive(4'b1111, {2'd3,2'd2,2'd1,2'd0}, 8'hFF, {4{16'hFFFF}});
    repeat (2) @(posedge clk);
    #1 check("ready_in_reset", 32'(bus.req_ready), 32'h0);
    drive('0, '0, '0, '0);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a);
      #1 check($sformatf("reset_rd%0d", a), 32'(bus.rd_data), 32'h0);
    end
    check("reset_merge", 32'(merge_cnt), 32'h0);

    for (int n = 0; n < 18; n++) begin
      drive(vec[n].valid, vec[n].addr, vec[n].be, vec[n].data);
      bus.rd_addr = vec[n].rd_addr;
      #2 check($sformatf("v%0d_ready", n), 32'(bus.req_ready), 32'(vec[n].exp_ready));
      sb.push_back('{n, vec[n].rd_addr, vec[n].exp_rd, vec[n].exp_merge});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      bus.rd_addr = e.rd_addr;
      #1 check($sformatf("v%0d_rd", e.idx), 32'(bus.rd_data), 32'(e.rd));
      check($sformatf("v%0d_merge", e.idx), 32'(merge_cnt), 32'(e.merge));
    end

    // Two disjoint-lane writers on one register merge every cycle until saturation.
    drive(4'b0011, {2'd0,2'd0,2'd1,2'd1}, {2'b00,2'b00,2'b10,2'b01},
          {16'h0,16'h0,16'h0200,16'h0001});
    bus.rd_addr = 2'd1;
    for (int c = 0; c < 260; c++) begin
      #2 check("sat_ready", 32'(bus.req_ready), 32'h3);
      @(posedge clk);
      #1;
    end
    check("sat_merge", 32'(merge_cnt), 32'hFF);
    check("sat_rd", 32'(bus.rd_data), 32'h0201);

    // Reset in the middle of round-robin traffic.
    drive(4'b1111, 8'h00, 8'hFF, {16'hD003,16'hD002,16'hD001,16'hD000});
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    #1 check("midrst_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a);
      #1 check($sformatf("midrst_rd%0d", a), 32'(bus.rd_data), 32'h0);
    end
    check("midrst_merge", 32'(merge_cnt), 32'h0);
    check("midrst_first", 32'(bus.req_ready), 32'h1);
    bus.rd_addr = 2'd0;
    @(posedge clk);
    #1 check("midrst_wr", 32'(bus.rd_data), 32'hD000);
    check("midrst_next", 32'(bus.req_ready), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
